imem_fetch_controller: RTL

- Sequences the instruction memory (32-bit word, byte-addressed; word index = Address/4, combinational read).
- Owns the PC and drives the memory Address.
- Registers each fetched instruction into a one-entry output slot with a valid/ready handshake to decode, and splits out the opcode/rd/rs1/rs2/imm fields.
- Handles redirects (branch/jump), a HALT opcode, and address faults.

---
 rtl/cpu_pkg.sv | 22 ++
 rtl/instr_field_split.sv | 18 +
 rtl/imem_fetch_controller.sv | 108 ++++++++++
 3 files changed

// File: rtl/cpu_pkg.sv
// cpu_pkg: instruction field layout, HALT opcode and fetch FSM state encodings.
// Shared by the fetch controller and by anything that decodes its output fields.
package cpu_pkg;
    localparam int OPCODE_W = 5;
    localparam int OP_HI    = 31;
    localparam int OP_LO    = 27;
    localparam int RD_HI    = 26;
    localparam int RD_LO    = 22;
    localparam int RS1_HI   = 21;
    localparam int RS1_LO   = 17;
    localparam int RS2_HI   = 16;
    localparam int RS2_LO   = 12;
    localparam int IMM_HI   = 11;
    localparam int IMM_LO   = 0;
    localparam logic [OPCODE_W-1:0] HALT_OP = 5'b11111;
    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        RUN   = 2'd1,
        HALT  = 2'd2,
        FAULT = 2'd3
    } fetch_state_t;
endpackage

// File: rtl/instr_field_split.sv
// instr_field_split: combinational split of a 32-bit instruction into its fields.
// Ports: instr in; opcode/rd/rs1/rs2 (5b) and imm (12b) out.
module instr_field_split
    import cpu_pkg::*;
(
    input  logic [31:0]         instr,
    output logic [OPCODE_W-1:0] opcode,
    output logic [4:0]          rd,
    output logic [4:0]          rs1,
    output logic [4:0]          rs2,
    output logic [11:0]         imm
);
    assign opcode = instr[OP_HI:OP_LO];
    assign rd     = instr[RD_HI:RD_LO];
    assign rs1    = instr[RS1_HI:RS1_LO];
    assign rs2    = instr[RS2_HI:RS2_LO];
    assign imm    = instr[IMM_HI:IMM_LO];
endmodule

// File: rtl/imem_fetch_controller.sv
// imem_fetch_controller: owns the PC, reads instruction memory and holds each fetched
// word in a one-entry valid/ready slot toward decode.
// Ports: clk, rst_n (async, active-low); en, redirect_valid/redirect_pc control;
// imem_addr/imem_instr memory side; out_* slot and decoded fields; state_o, halted,
// fault status; fetch_count counts accepted handshakes.
module imem_fetch_controller
    import cpu_pkg::*;
#(
    parameter int                      DATA_WIDTH  = 32,
    parameter int                      MEM_DEPTH   = 256,
    parameter logic [DATA_WIDTH-1:0]   RESET_PC    = '0,
    parameter logic [OPCODE_W-1:0]     HALT_OPCODE = HALT_OP
)(
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic                  en,
    input  logic                  redirect_valid,
    input  logic [DATA_WIDTH-1:0] redirect_pc,
    output logic [DATA_WIDTH-1:0] imem_addr,
    input  logic [DATA_WIDTH-1:0] imem_instr,
    output logic                  out_valid,
    input  logic                  out_ready,
    output logic [DATA_WIDTH-1:0] out_instr,
    output logic [DATA_WIDTH-1:0] out_pc,
    output logic [4:0]            out_opcode,
    output logic [4:0]            out_rd,
    output logic [4:0]            out_rs1,
    output logic [4:0]            out_rs2,
    output logic [11:0]           out_imm,
    output logic [1:0]            state_o,
    output logic                  halted,
    output logic                  fault,
    output logic [DATA_WIDTH-1:0] fetch_count
);
    localparam logic [DATA_WIDTH-1:0] PC_LIMIT = DATA_WIDTH'(MEM_DEPTH * 4);

    fetch_state_t          state, state_n;
    logic [DATA_WIDTH-1:0] pc;
    logic                  slot_free, accept, redirect_bad, is_halt, capture;

    assign slot_free    = !out_valid || out_ready;
    // A redirect flushes the slot, so a handshake in that cycle is not counted.
    assign accept       = out_valid && out_ready && !redirect_valid;
    assign redirect_bad = (redirect_pc[1:0] != 2'b00) || (redirect_pc >= PC_LIMIT);
    assign is_halt      = imem_instr[OP_HI:OP_LO] == HALT_OPCODE;

    always_comb begin
        state_n = state;
        capture = 1'b0;
        if (redirect_valid)
            state_n = redirect_bad ? FAULT : (en ? RUN : IDLE);
        else begin
            case (state)
                IDLE: state_n = en ? RUN : IDLE;
                RUN: begin
                    if (pc >= PC_LIMIT)
                        state_n = FAULT;
                    else if (!en)
                        state_n = IDLE;
                    else if (slot_free) begin
                        capture = 1'b1;
                        state_n = is_halt ? HALT : RUN;
                    end
                end
                default: state_n = state;
            endcase
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state       <= IDLE;
            pc          <= RESET_PC;
            out_valid   <= 1'b0;
            out_instr   <= '0;
            out_pc      <= '0;
            fetch_count <= '0;
        end else begin
            state     <= state_n;
            // HALT is emitted but leaves pc parked on the HALT word.
            if (redirect_valid)
                pc <= redirect_pc;
            else if (capture && !is_halt)
                pc <= pc + DATA_WIDTH'(4);
            if (capture) begin
                out_instr <= imem_instr;
                out_pc    <= pc;
            end
            out_valid <= capture || (out_valid && !out_ready && !redirect_valid);
            if (accept)
                fetch_count <= fetch_count + DATA_WIDTH'(1);
        end
    end

    assign imem_addr = pc;
    assign state_o   = state;
    assign halted    = state == HALT;
    assign fault     = state == FAULT;

    instr_field_split u_split (
        .instr  (out_instr),
        .opcode (out_opcode),
        .rd     (out_rd),
        .rs1    (out_rs1),
        .rs2    (out_rs2),
        .imm    (out_imm)
    );
endmodule
